// File: rtl/mux2to1v_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux2to1v_arbiter_if
//
// Bundles the two packet sources (A, B), the downstream consumer handshake
// and the arbiter status outputs of mux2to1v_arbiter.
//
//   a_valid/a_data/a_last : source A beat, a_ready back from the arbiter
//   b_valid/b_data/b_last : source B beat, b_ready back from the arbiter
//   out_valid/out_data/out_last : registered output beat, out_ready from
//                                 the consumer
//   sel   : registered mux select (0 = A, 1 = B)
//   trunc : one-cycle pulse when a grant is cut at the beat limit
//
// Modports:
//   master : the environment side (drives sources and consumer ready)
//   slave  : the arbiter side
// ----------------------------------------------------------------------------
interface mux2to1v_arbiter_if #(
    parameter int WIDTH = 100
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_ready;

    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    logic             sel;
    logic             trunc;

    modport master (
        output a_valid, a_data, a_last,
        output b_valid, b_data, b_last,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_data, out_last,
        input  sel, trunc
    );

    modport slave (
        input  a_valid, a_data, a_last,
        input  b_valid, b_data, b_last,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_data, out_last,
        output sel, trunc
    );
endinterface

// File: rtl/mux2to1v_arbiter.sv
// ----------------------------------------------------------------------------
// mux2to1v_arbiter
//
// Round-robin arbiter owning the shared WIDTH-bit 2:1 word mux between two
// packet sources A and B. A grant is locked for a whole packet (until the
// source's last beat, or a forced cut after MAX_BEATS beats). Each accepted
// beat is captured in a one-entry output register with a valid/ready
// handshake towards the consumer.
//
// Ports:
//   clk      : rising-edge clock
//   areset_n : asynchronous active-low reset
//   bus      : mux2to1v_arbiter_if.slave (sources, consumer, sel, trunc)
//
// Parameters:
//   WIDTH     : data word width in bits
//   MAX_BEATS : beats per grant before a forced release (2..255)
// ----------------------------------------------------------------------------
module mux2to1v_arbiter #(
    parameter int WIDTH     = 100,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 areset_n,
    mux2to1v_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    // Beat index at which a packet without a last marker is cut.
    localparam logic [7:0] CUT_IDX = 8'(MAX_BEATS - 1);

    state_t           state_reg, state_next;
    logic             sel_reg, sel_next;
    logic             last_b_reg;          // 1: B was the last source served
    logic [7:0]       beat_cnt_reg;
    logic             trunc_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;

    logic [WIDTH-1:0] mux_data;
    logic             mux_valid;
    logic             mux_last;
    logic             busy;
    logic             space;
    logic             accept;
    logic             force_cut;
    logic             end_grant;
    logic             pick_b;

    // ------------------------------------------------------------------
    // Shared word mux, steered by the registered select. While in a BUSY
    // state sel_reg always names the granted source, so the mux output is
    // the granted beat.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_word_mux
            assign mux_data[gi] = sel_reg ? bus.b_data[gi] : bus.a_data[gi];
        end
    endgenerate

    assign mux_valid = sel_reg ? bus.b_valid : bus.a_valid;
    assign mux_last  = sel_reg ? bus.b_last  : bus.a_last;

    // The output register can take a new beat when empty or being drained.
    assign busy      = (state_reg != IDLE);
    assign space     = !out_valid_reg || bus.out_ready;
    assign accept    = busy && mux_valid && space;
    assign force_cut = (beat_cnt_reg == CUT_IDX) && !mux_last;
    assign end_grant = accept && (mux_last || force_cut);

    assign bus.a_ready   = (state_reg == BUSY_A) && space;
    assign bus.b_ready   = (state_reg == BUSY_B) && space;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.sel       = sel_reg;
    assign bus.trunc     = trunc_reg;

    // ------------------------------------------------------------------
    // Next-state logic. On a tie the source not served last wins; sel
    // follows the grant on entry to BUSY and holds through IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        pick_b     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.a_valid || bus.b_valid) begin
                    pick_b     = bus.b_valid && (!bus.a_valid || !last_b_reg);
                    state_next = pick_b ? BUSY_B : BUSY_A;
                    sel_next   = pick_b;
                end
            end
            BUSY_A, BUSY_B: begin
                // Leaving BUSY always passes through one IDLE cycle, which
                // is the arbitration bubble between packets.
                if (end_grant) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state: FSM, select, round-robin pointer, beat counter, trunc.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_reg    <= IDLE;
            sel_reg      <= 1'b0;
            last_b_reg   <= 1'b1;   // A wins the first tie
            beat_cnt_reg <= 8'd0;
            trunc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            trunc_reg <= end_grant && force_cut;
            if (end_grant) begin
                last_b_reg   <= sel_reg;
                beat_cnt_reg <= 8'd0;
            end else if (accept) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // One-entry output register. A held beat is never overwritten while
    // the consumer stalls, because accept requires space.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= mux_data;
                out_last_reg  <= mux_last || force_cut;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule
